// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, ALU function codes and control state encoding.
package mu0_pkg;

  // Opcodes carried in IR[15:12]
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  // ALU function select, shared with the MU0 ALU
  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Control state encoding
  localparam logic [1:0] ST_FETCH   = 2'b00;
  localparam logic [1:0] ST_EXECUTE = 2'b01;
  localparam logic [1:0] ST_HALT    = 2'b10;

endpackage

// File: rtl/mu0_control.sv
// MU0 control unit: two-cycle FETCH/EXECUTE sequencer with optional HALT on STP.
module mu0_control
  import mu0_pkg::*;
#(
  parameter bit HALT_ON_STP = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic [1:0] M,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted
);

  logic [1:0] state;

  // State register with next-state selection; HALT is left only by Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:   state <= ST_EXECUTE;
        ST_EXECUTE: state <= (HALT_ON_STP && (F == OP_STP)) ? ST_HALT : ST_FETCH;
        ST_HALT:    state <= ST_HALT;
        default:    state <= ST_FETCH;
      endcase
    end
  end

  // Output decode; Reset gates everything low so a write in progress drops at once
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    M        = ALU_Y;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Halted   = 1'b0;
    if (!Reset) begin
      case (state)
        ST_FETCH: begin
          Rd    = 1'b1;
          IR_En = 1'b1;
          M     = ALU_INC;
          PC_En = 1'b1;
        end
        ST_EXECUTE: begin
          Addr_sel = 1'b1;
          case (F)
            OP_LDA: begin
              Rd     = 1'b1;
              Y_sel  = 1'b1;
              Acc_En = 1'b1;
            end
            OP_STA: begin
              Wr    = 1'b1;
              X_sel = 1'b1;
            end
            OP_ADD: begin
              Rd     = 1'b1;
              X_sel  = 1'b1;
              Y_sel  = 1'b1;
              M      = ALU_ADD;
              Acc_En = 1'b1;
            end
            OP_SUB: begin
              Rd     = 1'b1;
              X_sel  = 1'b1;
              Y_sel  = 1'b1;
              M      = ALU_SUB;
              Acc_En = 1'b1;
            end
            OP_JMP:  PC_En = 1'b1;
            OP_JGE:  PC_En = ~N;
            OP_JNE:  PC_En = ~Z;
            default: ;
          endcase
        end
        ST_HALT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 Parameter HALT_ON_STP, default 1, meaning: 1 = STP enters HALT; 0 = STP is a NOP.
REQ-002 Clk  input  1  rising-edge system clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 F  input  4  opcode, from instruction register bits [15:12].
REQ-005 N  input  1  accumulator negative flag, Acc[15].
REQ-006 Z  input  1  accumulator zero flag, Acc == 0.
REQ-007 X_sel  output  1  ALU X source: 0 = PC, 1 = Acc.
REQ-008 Y_sel  output  1  ALU Y source: 0 = IR[11:0] zero-extended, 1 = memory read data.
REQ-009 Addr_sel  output  1  memory address source: 0 = PC, 1 = IR[11:0].
REQ-010 PC_En, IR_En, Acc_En  output  1 each  register load enables, sampled on the next Clk edge.
REQ-011 M  output  2  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y.
REQ-012 Rd, Wr  output  1 each  memory read and write strobes.
REQ-013 Halted  output  1  high while in HALT.

Function
REQ-014 The state register SHALL hold one of FETCH, EXECUTE, HALT; all outputs SHALL be a combinational decode of state, F, N and Z.
REQ-015 State transitions SHALL be:
  - FETCH -> EXECUTE, unconditionally.
  - EXECUTE -> HALT when F=7 and HALT_ON_STP=1.
  - EXECUTE -> FETCH otherwise.
  - HALT -> HALT until Reset.
REQ-016 In FETCH the outputs SHALL be Addr_sel=0, Rd=1, IR_En=1, X_sel=0, M=10, PC_En=1; all other outputs 0.
REQ-017 In EXECUTE, Addr_sel SHALL be 1, and every output not listed below for the current F SHALL be 0:
  - F=0 LDA: Rd=1, Y_sel=1, M=00, Acc_En=1.
  - F=1 STA: Wr=1, X_sel=1.
  - F=2 ADD: Rd=1, X_sel=1, Y_sel=1, M=01, Acc_En=1.
  - F=3 SUB: Rd=1, X_sel=1, Y_sel=1, M=11, Acc_En=1.
  - F=4 JMP: Y_sel=0, M=00, PC_En=1.
  - F=5 JGE: Y_sel=0, M=00, PC_En=~N.
  - F=6 JNE: Y_sel=0, M=00, PC_En=~Z.
  - F=7 STP: no enables, no strobes.
  - F=8..15: NOP (no enables, no strobes), return to FETCH.
REQ-018 In HALT all enables and strobes SHALL be 0, M SHALL be 00, and Halted SHALL be 1; Halted SHALL be 0 in every other state.
REQ-019 Every instruction SHALL take exactly 2 cycles (FETCH + EXECUTE); no state SHALL ever be skipped.
REQ-020 Rd and Wr SHALL never both be 1 in the same cycle.
REQ-021 N and Z SHALL be used only in EXECUTE for F=5 and F=6, and SHALL be taken from the current cycle's values.
REQ-022 F changes during FETCH SHALL NOT affect FETCH outputs.

Reset
REQ-023 Reset high SHALL force state to FETCH asynchronously, with no dependence on Clk.
REQ-024 While Reset is high, all enables, Rd, Wr and Halted SHALL be 0, and M, X_sel, Y_sel and Addr_sel SHALL be 0.
REQ-025 After Reset deasserts, the first Clk edge SHALL execute a FETCH.
REQ-026 Reset asserted mid-EXECUTE or in HALT SHALL abort that state with no write (Wr=0 immediately).

Structure
REQ-027 A shared package mu0_pkg SHALL hold:
  - opcode constants (LDA..STP);
  - the ALU M codes (ALU_Y, ALU_ADD, ALU_INC, ALU_SUB);
  - the state encoding (2 bits).
The MU0 ALU SHALL use the same M constants.
REQ-028 mu0_control SHALL be a single module with no sub-modules: one state-register process and one output-decode process.

Verification
REQ-029 Reset, then release; F=0 during cycle 1 -> cycle 1 FETCH outputs (Rd=1, IR_En=1, PC_En=1, M=10); cycle 2 LDA outputs (Rd=1, Y_sel=1, Acc_En=1, M=00); cycle 3 FETCH.
REQ-030 F=5 with N=1, then F=5 with N=0 -> PC_En=0, then PC_En=1; F=6 with Z=1, then Z=0 -> PC_En=0, then PC_En=1.
REQ-031 F=1 in EXECUTE -> Wr=1, Rd=0, Addr_sel=1, X_sel=1, Acc_En=0.
REQ-032 F=7 with HALT_ON_STP=1 -> Halted=1 from the next cycle for 10 cycles with all enables 0; Reset pulse -> FETCH.
REQ-033 F=7 with HALT_ON_STP=0, then F=12 -> both behave as NOP and each returns to FETCH after one EXECUTE cycle.
REQ-034 Reset asserted between Clk edges during a STA EXECUTE -> Wr falls to 0 immediately; after release, the next edge performs a FETCH.
